// File: rtl/nvram_store_recall_ctrl.sv
// rtl/nvram_store_recall_ctrl.sv - NVRAM shadow RAM store/recall sequencer
//
// Moves the full 256-byte image between a 256x8 shadow RAM and a byte-wide
// backing store. Outside a transfer the CPU owns the RAM port directly.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   NVRAMn, WRphi2n, BA,       CPU chip select, write strobe, address and
//   cpu_din                    write data (pass-through to RAM when idle)
//   STORE                      rising edge starts RAM -> backing store copy
//   RECALLn                    falling edge starts backing store -> RAM copy
//   ram_we_n, ram_addr,        shadow RAM write enable, address, write data
//   ram_din, ram_dout          and read data (one cycle after ram_addr)
//   host_rd, host_wr,          backing-store byte request handshake,
//   host_addr, host_wdata,     completed by host_ack
//   host_rdata, host_ack
//   busy, done                 transfer active, one-cycle completion pulse
//   cpu_lost                   sticky flag: a CPU write arrived mid-transfer

module nvram_store_recall_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       NVRAMn,
    input  logic       WRphi2n,
    input  logic [7:0] BA,
    input  logic [7:0] cpu_din,
    input  logic       STORE,
    input  logic       RECALLn,
    output logic       ram_we_n,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout,
    output logic       host_rd,
    output logic       host_wr,
    output logic [7:0] host_addr,
    output logic [7:0] host_wdata,
    input  logic [7:0] host_rdata,
    input  logic       host_ack,
    output logic       busy,
    output logic       done,
    output logic       cpu_lost
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RCL_REQ = 3'd1,
        RCL_WR  = 3'd2,
        STO_RD  = 3'd3,
        STO_REQ = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] counter;
    logic [7:0] rd_byte;    // byte fetched from the backing store during recall
    logic [7:0] wdata_q;    // RAM byte held for the remainder of a store request
    logic       sto_first;  // first cycle of STO_REQ: ram_dout is live this cycle
    logic       store_s, store_p;
    logic       recall_s, recall_p;
    logic       store_rise, recall_fall;

    assign store_rise  = store_s & ~store_p;
    assign recall_fall = ~recall_s & recall_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= 8'd0;
            rd_byte   <= 8'd0;
            wdata_q   <= 8'd0;
            sto_first <= 1'b0;
            store_s   <= 1'b0;
            store_p   <= 1'b0;
            recall_s  <= 1'b1;
            recall_p  <= 1'b1;
            done      <= 1'b0;
            cpu_lost  <= 1'b0;
        end else begin
            store_s   <= STORE;
            store_p   <= store_s;
            recall_s  <= RECALLn;
            recall_p  <= recall_s;
            done      <= 1'b0;
            sto_first <= 1'b0;

            if (state != IDLE && !NVRAMn && !WRphi2n)
                cpu_lost <= 1'b1;

            case (state)
                IDLE: begin
                    // Recall has priority; a coincident store edge is dropped.
                    if (recall_fall) begin
                        counter <= 8'd0;
                        state   <= RCL_REQ;
                    end else if (store_rise) begin
                        counter <= 8'd0;
                        state   <= STO_RD;
                    end
                end
                RCL_REQ: begin
                    if (host_ack) begin
                        rd_byte <= host_rdata;
                        state   <= RCL_WR;
                    end
                end
                RCL_WR: begin
                    if (counter == 8'hFF) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        counter <= counter + 8'd1;
                        state   <= RCL_REQ;
                    end
                end
                STO_RD: begin
                    sto_first <= 1'b1;
                    state     <= STO_REQ;
                end
                STO_REQ: begin
                    if (sto_first)
                        wdata_q <= ram_dout;
                    if (host_ack) begin
                        if (counter == 8'hFF) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            counter <= counter + 8'd1;
                            state   <= STO_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port: CPU pass-through when idle, sequencer-owned otherwise.
    always_comb begin
        ram_we_n = 1'b1;
        ram_addr = counter;
        ram_din  = rd_byte;
        case (state)
            IDLE: begin
                ram_we_n = NVRAMn | WRphi2n;
                ram_addr = BA;
                ram_din  = cpu_din;
            end
            RCL_WR:  ram_we_n = 1'b0;
            default: ram_we_n = 1'b1;
        endcase
    end

    assign busy       = (state != IDLE);
    assign host_rd    = (state == RCL_REQ);
    assign host_wr    = (state == STO_REQ);
    assign host_addr  = counter;
    // The RAM byte is only valid on the first STO_REQ cycle; after that the
    // captured copy keeps host_wdata stable for a slow host.
    assign host_wdata = sto_first ? ram_dout : wdata_q;

endmodule

// File: tb/tb_nvram_store_recall_ctrl.sv
// tb/tb_nvram_store_recall_ctrl.sv - directed bench for nvram_store_recall_ctrl

module tb_nvram_store_recall_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       NVRAMn = 1'b1;
    logic       WRphi2n = 1'b1;
    logic [7:0] BA = 8'd0;
    logic [7:0] cpu_din = 8'd0;
    logic       STORE = 1'b0;
    logic       RECALLn = 1'b1;
    logic       ram_we_n;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'd0;
    logic       host_rd;
    logic       host_wr;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata = 8'd0;
    logic       host_ack = 1'b0;
    logic       busy;
    logic       done;
    logic       cpu_lost;

    nvram_store_recall_ctrl dut (
        .clk(clk), .reset(reset), .NVRAMn(NVRAMn), .WRphi2n(WRphi2n),
        .BA(BA), .cpu_din(cpu_din), .STORE(STORE), .RECALLn(RECALLn),
        .ram_we_n(ram_we_n), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .host_rd(host_rd), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack), .busy(busy),
        .done(done), .cpu_lost(cpu_lost)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic [7:0] bstore [0:255];
    int lat = 0;
    int req_cnt = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, ord_err = 0, both_err = 0;
    int n_chk = 0, n_pass = 0;

    // Shadow RAM: synchronous write, registered read.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (!ram_we_n)
            mem[ram_addr] = ram_din;
    end

    // Backing store: acks after lat waiting cycles.
    always @(negedge clk) begin
        if (host_rd || host_wr) begin
            host_rdata = bstore[host_addr];
            host_ack   = (req_cnt >= lat);
            req_cnt    = req_cnt + 1;
        end else begin
            host_ack = 1'b0;
            req_cnt  = 0;
        end
    end

    always @(posedge clk) begin
        if (host_rd && host_wr) both_err = both_err + 1;
        if (host_rd && host_ack) rd_cnt = rd_cnt + 1;
        if (host_wr && host_ack) begin
            if (host_addr != 8'(wr_cnt) || host_wdata != 8'(wr_cnt))
                ord_err = ord_err + 1;
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        NVRAMn = 1'b0; WRphi2n = 1'b0; BA = a; cpu_din = d;
        @(posedge clk); #1;
        NVRAMn = 1'b1; WRphi2n = 1'b1;
    endtask

    task automatic wait_done(input string tag, output int busy_cyc);
        logic to;
        to = 1'b1;
        busy_cyc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy) busy_cyc = busy_cyc + 1;
            if (done) begin to = 1'b0; break; end
        end
        check(tag, 32'(to), 32'd0);
    endtask

    task automatic wait_rd_addr(input string tag, input logic [7:0] a);
        logic to;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (host_rd && host_addr == a) begin to = 1'b0; break; end
        end
        check(tag, 32'(to), 32'd0);
    endtask

    initial begin
        int bc, r0, w0, d0, mm, mm2;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lost", 32'(cpu_lost), 32'd0);
        check("rst_hrd_hwr", 32'({host_rd, host_wr}), 32'd0);
        check("rst_we_n", 32'(ram_we_n), 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rel_no_edge", 32'(busy), 32'd0);

        // CPU pass-through in idle
        NVRAMn = 1'b0; WRphi2n = 1'b0; BA = 8'h12; cpu_din = 8'hA5;
        #1;
        check("cpu_we_n", 32'(ram_we_n), 32'd0);
        check("cpu_addr", 32'(ram_addr), 32'h12);
        check("cpu_din", 32'(ram_din), 32'hA5);
        @(posedge clk); #1;
        NVRAMn = 1'b1; WRphi2n = 1'b1;
        check("cpu_mem", 32'(mem[8'h12]), 32'hA5);

        // Recall, 2-cycle ack latency
        for (int i = 0; i < 256; i++) bstore[i] = 8'(i ^ 8'hFF);
        lat = 2;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk); RECALLn = 1'b0;
        wait_done("rcl_done", bc);
        repeat (3) @(negedge clk);
        mm = 0;
        for (int i = 0; i < 256; i++) if (mem[8'(i)] !== 8'(i ^ 8'hFF)) mm++;
        check("rcl_mem_mm", 32'(mm), 32'd0);
        check("rcl_rd_cnt", 32'(rd_cnt - r0), 32'd256);
        check("rcl_wr_cnt", 32'(wr_cnt - w0), 32'd0);
        check("rcl_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("rcl_busy_after", 32'(busy), 32'd0);
        check("rcl_lost", 32'(cpu_lost), 32'd0);
        RECALLn = 1'b1;
        repeat (4) @(negedge clk);

        // Store, RAM preloaded N = N
        for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'(i));
        lat = 1;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk); STORE = 1'b1;
        wait_done("sto_done", bc);
        repeat (3) @(negedge clk);
        check("sto_wr_cnt", 32'(wr_cnt - w0), 32'd256);
        check("sto_order_err", 32'(ord_err), 32'd0);
        check("sto_rd_cnt", 32'(rd_cnt - r0), 32'd0);
        check("sto_done_cnt", 32'(done_cnt - d0), 32'd1);
        STORE = 1'b0;
        repeat (4) @(negedge clk);

        // Simultaneous store and recall edges, zero-latency host
        for (int i = 0; i < 256; i++) bstore[i] = 8'(i ^ 8'h5A);
        lat = 0;
        r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clk); STORE = 1'b1; RECALLn = 1'b0;
        wait_done("sim_done", bc);
        repeat (3) @(negedge clk);
        check("sim_busy_cyc", 32'(bc), 32'd512);
        check("sim_wr_cnt", 32'(wr_cnt - w0), 32'd0);
        check("sim_rd_cnt", 32'(rd_cnt - r0), 32'd256);
        mm = 0;
        for (int i = 0; i < 256; i++) if (mem[8'(i)] !== 8'(i ^ 8'h5A)) mm++;
        check("sim_mem_mm", 32'(mm), 32'd0);
        RECALLn = 1'b1;
        repeat (4) @(negedge clk);

        // CPU write dropped during recall at byte 10
        for (int i = 0; i < 256; i++) bstore[i] = 8'(i + 7);
        @(negedge clk); RECALLn = 1'b0;
        wait_rd_addr("lost_wait", 8'd10);
        cpu_write(8'd5, 8'h00);
        wait_done("lost_done", bc);
        repeat (2) @(negedge clk);
        check("lost_mem5", 32'(mem[8'd5]), 32'd12);
        check("lost_flag", 32'(cpu_lost), 32'd1);
        STORE = 1'b0; RECALLn = 1'b1;
        repeat (3) @(negedge clk);
        check("lost_sticky", 32'(cpu_lost), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("lost_clr", 32'(cpu_lost), 32'd0);

        // Reset mid-recall at byte 100
        for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'hEE);
        for (int i = 0; i < 256; i++) bstore[i] = 8'(i ^ 8'h33);
        d0 = done_cnt;
        @(negedge clk); RECALLn = 1'b0;
        wait_rd_addr("abort_wait", 8'd100);
        reset = 1'b1; RECALLn = 1'b1;
        @(posedge clk); #1;
        check("abort_hrd", 32'(host_rd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        mm = 0; mm2 = 0;
        for (int i = 0; i < 100; i++) if (mem[8'(i)] !== 8'(i ^ 8'h33)) mm++;
        for (int i = 100; i < 256; i++) if (mem[8'(i)] !== 8'hEE) mm2++;
        check("abort_lo_mm", 32'(mm), 32'd0);
        check("abort_hi_mm", 32'(mm2), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("rd_wr_overlap", 32'(both_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
